// File: rtl/modl_phase_sequencer.sv
// Phase-table sequencer for the non-overlapping modulation clock generator.
// Each step holds the generator for SETTLE_CYC cycles, then presents the phase for DWELL cycles.
module modl_phase_sequencer #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_addr_i,
  input  logic [4:0]  wr_data_i,
  input  logic [2:0]  last_idx_i,
  input  logic [15:0] dwell_i,
  input  logic        loop_i,
  input  logic        start_i,
  input  logic        abort_i,
  output logic [4:0]  phase_sel_o,
  output logic        gen_hold_o,
  output logic        step_valid_o,
  output logic [2:0]  step_idx_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {IDLE, SETTLE, DWELL, DONE} state_e;

  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYC - 1);

  state_e      state_q;
  logic [4:0]  table_q [8];
  logic [2:0]  idx_q;
  logic [2:0]  lastIdx_q;
  logic [15:0] dwellLen_q;
  logic [7:0]  settleCnt_q;
  logic [15:0] dwellCnt_q;
  logic [4:0]  phaseSel_q;
  logic        genHold_q;
  logic        stepValid_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] dwellLen_d;
  logic        lastStep_d;
  logic [2:0]  nextIdx_d;

  always_comb begin
    dwellLen_d = (dwell_i == 16'd0) ? 16'd1 : dwell_i;
    lastStep_d = (idx_q == lastIdx_q);
    nextIdx_d  = lastStep_d ? 3'd0 : idx_q + 3'd1;
  end

  // Writes land at the edge, so a load of the same entry on that edge still sees the old value.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 8; i++) table_q[i] <= '0;
    end else if (wr_en_i) begin
      table_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lastIdx_q   <= '0;
      dwellLen_q  <= '0;
      settleCnt_q <= '0;
      dwellCnt_q  <= '0;
      phaseSel_q  <= '0;
      genHold_q   <= 1'b0;
      stepValid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort_i && (state_q != IDLE)) begin
      state_q     <= IDLE;
      genHold_q   <= 1'b0;
      stepValid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q     <= SETTLE;
            idx_q       <= 3'd0;
            lastIdx_q   <= last_idx_i;
            dwellLen_q  <= dwellLen_d;
            settleCnt_q <= SettleLoad;
            phaseSel_q  <= table_q[0];
            genHold_q   <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        SETTLE: begin
          if (settleCnt_q == 8'd0) begin
            state_q     <= DWELL;
            dwellCnt_q  <= dwellLen_q - 16'd1;
            genHold_q   <= 1'b0;
            stepValid_q <= 1'b1;
          end else begin
            settleCnt_q <= settleCnt_q - 8'd1;
          end
        end

        DWELL: begin
          if (dwellCnt_q == 16'd0) begin
            stepValid_q <= 1'b0;
            // LOOP is deliberately sampled live here rather than latched at START.
            if (!lastStep_d || loop_i) begin
              state_q     <= SETTLE;
              idx_q       <= nextIdx_d;
              phaseSel_q  <= table_q[nextIdx_d];
              settleCnt_q <= SettleLoad;
              genHold_q   <= 1'b1;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            dwellCnt_q <= dwellCnt_q - 16'd1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign phase_sel_o  = phaseSel_q;
  assign gen_hold_o   = genHold_q;
  assign step_valid_o = stepValid_q;
  assign step_idx_o   = idx_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_modl_phase_sequencer.sv
// Self-checking bench for modl_phase_sequencer: directed vectors, spec scenarios and
// randomized traffic compared against a step-position reference model.
module tb_modl_phase_sequencer;

  localparam int SettleCyc = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetN;
  logic        wrEn;
  logic [2:0]  wrAddr;
  logic [4:0]  wrData;
  logic [2:0]  lastIdx;
  logic [15:0] dwell;
  logic        loopIn;
  logic        start;
  logic        abortIn;
  logic [4:0]  phaseSel;
  logic        genHold;
  logic        stepValid;
  logic [2:0]  stepIdx;
  logic        busy;
  logic        done;

  modl_phase_sequencer #(.SETTLE_CYC(SettleCyc)) dut (
    .clk_i        (clock),
    .reset_n_i    (resetN),
    .wr_en_i      (wrEn),
    .wr_addr_i    (wrAddr),
    .wr_data_i    (wrData),
    .last_idx_i   (lastIdx),
    .dwell_i      (dwell),
    .loop_i       (loopIn),
    .start_i      (start),
    .abort_i      (abortIn),
    .phase_sel_o  (phaseSel),
    .gen_hold_o   (genHold),
    .step_valid_o (stepValid),
    .step_idx_o   (stepIdx),
    .busy_o       (busy),
    .done_o       (done)
  );

  typedef struct {
    logic        rstn;
    logic        start;
    logic        abort;
    logic        wrEn;
    logic [2:0]  wrAddr;
    logic [4:0]  wrData;
    logic [2:0]  lastIdx;
    logic [15:0] dwell;
    logic        loopIn;
    logic [11:0] expOut;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: a run is a step index plus the cycle position inside that step.
  int mTable[8];
  bit mRun;
  bit mDone;
  int mIdx;
  int mPos;
  int mLast;
  int mDwell;
  int mPhase;

  task automatic modelEdge();
    if (!resetN) begin
      for (int i = 0; i < 8; i++) mTable[i] = 0;
      mRun = 0; mDone = 0; mIdx = 0; mPos = 0; mLast = 0; mDwell = 1; mPhase = 0;
      return;
    end
    if ((mRun || mDone) && abortIn) begin
      mRun = 0;
      mDone = 0;
    end else if (mDone) begin
      mDone = 0;
    end else if (mRun) begin
      mPos++;
      if (mPos == SettleCyc + mDwell) begin
        mPos = 0;
        if (mIdx < mLast) begin
          mIdx++;
          mPhase = mTable[mIdx];
        end else if (loopIn) begin
          mIdx = 0;
          mPhase = mTable[0];
        end else begin
          mRun = 0;
          mDone = 1;
        end
      end
    end else if (start) begin
      mRun = 1;
      mPos = 0;
      mIdx = 0;
      mLast = int'(lastIdx);
      mDwell = (dwell == 16'd0) ? 1 : int'(dwell);
      mPhase = mTable[0];
    end
    if (wrEn) mTable[wrAddr] = int'(wrData);
  endtask

  function automatic logic [11:0] modelOut();
    return {5'(mPhase), (mRun && mPos < SettleCyc), (mRun && mPos >= SettleCyc),
            3'(mIdx), mRun, mDone};
  endfunction

  function automatic logic [11:0] dutOut();
    return {phaseSel, genHold, stepValid, stepIdx, busy, done};
  endfunction

  function automatic logic [11:0] packExp(int p, int h, int v, int i, int b, int d);
    return {5'(p), (h != 0), (v != 0), 3'(i), (b != 0), (d != 0)};
  endfunction

  task automatic addVec(int rstn, int st, int ab, int we, int wa, int wd, int li, int dw,
                        int lp, logic [11:0] expOut);
    vec_t v;
    v.rstn = (rstn != 0); v.start = (st != 0); v.abort = (ab != 0); v.wrEn = (we != 0);
    v.wrAddr = 3'(wa); v.wrData = 5'(wd); v.lastIdx = 3'(li); v.dwell = 16'(dw);
    v.loopIn = (lp != 0); v.expOut = expOut;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    modelEdge();
    @(negedge clock);
  endtask

  task automatic checkOutput(string name, int cyc);
    checks++;
    if (dutOut() === modelOut()) passes++;
    else $display("[TB] FAIL %s cycle %0d: got {phase,hold,valid,idx,busy,done}=%h expected %h",
                  name, cyc, dutOut(), modelOut());
  endtask

  task automatic checkValue(string name, int actual, int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic setIdle();
    resetN = 1'b1; start = 1'b0; abortIn = 1'b0; wrEn = 1'b0;
  endtask

  task automatic doReset();
    resetN = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("reset", 0);
    setIdle();
  endtask

  task automatic writeEntry(int a, int d);
    wrEn = 1'b1; wrAddr = 3'(a); wrData = 5'(d);
    applyStimulus();
    wrEn = 1'b0;
    checkOutput("write", 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int passTab[3];
    int loopTab[4];
    int doneAt;

    resetN = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0; lastIdx = '0;
    dwell = '0; loopIn = 1'b0; start = 1'b0; abortIn = 1'b0;

    // rstn start abort wrEn wrAddr wrData lastIdx dwell loop | phase hold valid idx busy done
    addVec(0, 0, 0, 0, 0,  0, 0, 0, 0, packExp( 0, 0, 0, 0, 0, 0));
    addVec(1, 0, 0, 1, 0, 17, 0, 0, 0, packExp( 0, 0, 0, 0, 0, 0));
    addVec(1, 1, 0, 0, 0,  0, 0, 0, 0, packExp(17, 1, 0, 0, 1, 0));
    addVec(1, 1, 0, 0, 0,  0, 5, 9, 0, packExp(17, 1, 0, 0, 1, 0));
    addVec(1, 0, 0, 0, 0,  0, 0, 0, 0, packExp(17, 1, 0, 0, 1, 0));
    addVec(1, 0, 0, 0, 0,  0, 0, 0, 0, packExp(17, 1, 0, 0, 1, 0));
    addVec(1, 0, 0, 0, 0,  0, 0, 0, 0, packExp(17, 0, 1, 0, 1, 0));
    addVec(1, 0, 0, 0, 0,  0, 0, 0, 0, packExp(17, 0, 0, 0, 0, 1));
    addVec(1, 0, 0, 0, 0,  0, 0, 0, 0, packExp(17, 0, 0, 0, 0, 0));
    addVec(1, 1, 0, 0, 0,  0, 0, 2, 0, packExp(17, 1, 0, 0, 1, 0));
    addVec(1, 0, 1, 0, 0,  0, 0, 0, 0, packExp(17, 0, 0, 0, 0, 0));
    addVec(1, 0, 0, 0, 0,  0, 0, 0, 0, packExp(17, 0, 0, 0, 0, 0));

    @(negedge clock);
    foreach (vecs[k]) begin
      resetN = vecs[k].rstn; start = vecs[k].start; abortIn = vecs[k].abort;
      wrEn = vecs[k].wrEn; wrAddr = vecs[k].wrAddr; wrData = vecs[k].wrData;
      lastIdx = vecs[k].lastIdx; dwell = vecs[k].dwell; loopIn = vecs[k].loopIn;
      applyStimulus();
      checks++;
      if (dutOut() === vecs[k].expOut) passes++;
      else $display("[TB] FAIL vector %0d: got %h expected %h", k, dutOut(), vecs[k].expOut);
    end
    setIdle();

    // Single pass with mid-run config changes and an ignored START.
    passTab = '{3, 7, 12};
    doReset();
    writeEntry(0, 3); writeEntry(1, 7); writeEntry(2, 12);
    lastIdx = 3'd2; dwell = 16'd10; loopIn = 1'b0; start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("pass_start", 0);
    checkValue("pass_phase0", int'(phaseSel), 3);
    lastIdx = 3'd0; dwell = 16'd1;
    doneAt = -1;
    for (int n = 1; n <= 60 && doneAt < 0; n++) begin
      if (n == 20) start = 1'b1;
      applyStimulus();
      start = 1'b0;
      checkOutput("pass_seq", n);
      if (n % 14 == 0 && n < 42) checkValue("pass_phase", int'(phaseSel), passTab[n / 14]);
      if (done) doneAt = n;
    end
    checkValue("pass_done_time", doneAt, 3 * (SettleCyc + 10));
    applyStimulus();
    checkOutput("pass_after_done", 0);

    // Looping run; LOOP dropped during the third step.
    loopTab = '{5, 20, 5, 20};
    writeEntry(0, 5); writeEntry(1, 20);
    lastIdx = 3'd1; dwell = 16'd3; loopIn = 1'b1; start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("loop_start", 0);
    doneAt = -1;
    for (int n = 1; n <= 60 && doneAt < 0; n++) begin
      if (n == 15) loopIn = 1'b0;
      applyStimulus();
      checkOutput("loop_seq", n);
      if (n % 7 == 0 && n < 28) checkValue("loop_phase", int'(phaseSel), loopTab[n / 7]);
      if (done) doneAt = n;
    end
    checkValue("loop_done_time", doneAt, 4 * (SettleCyc + 3));

    // Write collision on the loading entry, then abort in step 1 settle and restart.
    writeEntry(0, 3); writeEntry(1, 7);
    lastIdx = 3'd1; dwell = 16'd2; loopIn = 1'b1; start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 6) begin wrEn = 1'b1; wrAddr = 3'd1; wrData = 5'd9; end
      if (n == 20) abortIn = 1'b1;
      applyStimulus();
      wrEn = 1'b0; abortIn = 1'b0;
      checkOutput("collide_seq", n);
      if (n == 6) checkValue("collide_old", int'(phaseSel), 7);
      if (n == 18) checkValue("collide_new", int'(phaseSel), 9);
    end
    checkValue("abort_busy", int'(busy), 0);
    checkValue("abort_hold", int'(genHold), 0);
    for (int n = 0; n < 5; n++) begin
      applyStimulus();
      checkValue("abort_no_done", int'(done), 0);
    end
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkValue("restart_idx", int'(stepIdx), 0);
    checkValue("restart_phase", int'(phaseSel), 3);

    // Reset held mid-dwell clears outputs and the table.
    abortIn = 1'b1;
    applyStimulus();
    abortIn = 1'b0;
    lastIdx = 3'd2; dwell = 16'd10; loopIn = 1'b0; start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int n = 0; n < 8; n++) applyStimulus();
    checkValue("pre_reset_valid", int'(stepValid), 1);
    resetN = 1'b0;
    applyStimulus();
    checkValue("reset_outputs", int'(dutOut()), 0);
    applyStimulus();
    applyStimulus();
    resetN = 1'b1;
    lastIdx = 3'd0; dwell = 16'd1; start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("reset_restart", 0);
    checkValue("reset_table", int'(phaseSel), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      resetN  = ($urandom_range(0, 199) != 0);
      abortIn = ($urandom_range(0, 59) == 0);
      start   = ($urandom_range(0, 7) == 0);
      wrEn    = ($urandom_range(0, 3) == 0);
      wrAddr  = 3'($urandom_range(0, 7));
      wrData  = 5'($urandom_range(0, 31));
      lastIdx = 3'($urandom_range(0, 7));
      dwell   = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) loopIn = ~loopIn;
      applyStimulus();
      checkOutput("random", c);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
